tmds_channel_decoder: RTL

Receive-side counterpart to the HDMI TMDS transmit path: recovers one TMDS channel from unaligned 10-bit words delivered by an upstream deserializer. It finds the symbol boundary by searching for TMDS control tokens, decodes aligned symbols back to 8-bit pixel data or 2-bit control codes, and reports lock. Three instances, one per data channel, sit behind the deserializers in the HDMI receive path on the pixel clock.

---
 rtl/tmds_channel_decoder.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/tmds_channel_decoder.sv
// One TMDS receive channel: finds the symbol boundary by searching for control
// tokens, decodes aligned symbols to pixel bytes or control codes, reports lock.
module tmds_channel_decoder #(
    parameter int LOCK_COUNT     = 8,
    parameter int SEARCH_TIMEOUT = 4096
) (
    input  logic       clk_low,
    input  logic       reset,
    input  logic [9:0] tmds_in,
    output logic [7:0] data,
    output logic [1:0] ctrl,
    output logic       de,
    output logic       locked,
    output logic [3:0] offset
);
    localparam int CW = $clog2(SEARCH_TIMEOUT);

    localparam logic [0:0] ST_SEARCH = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    localparam logic [CW-1:0] HIT_LOCK  = CW'(LOCK_COUNT);
    localparam logic [CW-1:0] MISS_LAST = CW'(SEARCH_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX   = '1;

    logic [9:0]    r_prev;
    logic [9:0]    r_sym;
    logic [3:0]    r_offset;
    logic [0:0]    r_state;
    logic [CW-1:0] r_hit;
    logic [CW-1:0] r_miss;
    logic          r_stale;
    logic [7:0]    r_data;
    logic [1:0]    r_ctrl;
    logic          r_de;

    logic [19:0]   w_window;
    logic [19:0]   w_shifted;
    logic [9:0]    w_aligned;
    logic          w_is_tok;
    logic [1:0]    w_code;
    logic [7:0]    w_d;
    logic [7:0]    w_dec;
    logic [CW-1:0] w_hit_inc;
    logic [CW-1:0] w_miss_inc;
    logic          w_lock_now;
    logic          w_timeout;

    assign w_window  = {tmds_in, r_prev};
    assign w_shifted = w_window >> r_offset;
    assign w_aligned = w_shifted[9:0];

    always_comb begin
        w_is_tok = 1'b1;
        w_code   = 2'b00;
        case (r_sym)
            10'h354: w_code = 2'b00;
            10'h0AB: w_code = 2'b01;
            10'h154: w_code = 2'b10;
            10'h2AB: w_code = 2'b11;
            default: w_is_tok = 1'b0;
        endcase
    end

    always_comb begin
        w_d      = r_sym[9] ? ~r_sym[7:0] : r_sym[7:0];
        w_dec    = '0;
        w_dec[0] = w_d[0];
        for (int unsigned i = 1; i < 8; i++) begin
            w_dec[i] = r_sym[8] ? (w_d[i] ^ w_d[i-1]) : ~(w_d[i] ^ w_d[i-1]);
        end
    end

    assign w_hit_inc  = (r_hit == CNT_MAX) ? r_hit : r_hit + CW'(1);
    assign w_miss_inc = (r_miss == CNT_MAX) ? r_miss : r_miss + CW'(1);
    // The symbol loaded on a slip edge still used the old offset, so it may not count as a hit.
    assign w_lock_now = w_is_tok && !r_stale && (w_hit_inc == HIT_LOCK);
    assign w_timeout  = (w_miss_inc == MISS_LAST);

    always_ff @(posedge clk_low or posedge reset) begin
        if (reset) begin
            r_prev   <= '0;
            r_sym    <= '0;
            r_offset <= '0;
            r_state  <= ST_SEARCH;
            r_hit    <= '0;
            r_miss   <= '0;
            r_stale  <= 1'b0;
            r_data   <= '0;
            r_ctrl   <= '0;
            r_de     <= 1'b0;
        end else begin
            r_prev  <= tmds_in;
            r_sym   <= w_aligned;
            r_stale <= 1'b0;
            case (r_state)
                ST_SEARCH: begin
                    r_data <= '0;
                    r_ctrl <= '0;
                    r_de   <= 1'b0;
                    if (w_lock_now) begin
                        r_state <= ST_LOCKED;
                        r_hit   <= '0;
                        r_miss  <= '0;
                    end else if (w_timeout) begin
                        r_offset <= (r_offset == 4'd9) ? 4'd0 : r_offset + 4'd1;
                        r_hit    <= '0;
                        r_miss   <= '0;
                        r_stale  <= 1'b1;
                    end else begin
                        r_hit  <= (w_is_tok && !r_stale) ? w_hit_inc : '0;
                        r_miss <= w_miss_inc;
                    end
                end
                default: begin
                    if (w_is_tok) begin
                        r_miss <= '0;
                        r_de   <= 1'b0;
                        r_ctrl <= w_code;
                        r_data <= '0;
                    end else if (w_timeout) begin
                        r_state <= ST_SEARCH;
                        r_hit   <= '0;
                        r_miss  <= '0;
                        r_de    <= 1'b0;
                        r_ctrl  <= '0;
                        r_data  <= '0;
                    end else begin
                        r_de   <= 1'b1;
                        r_data <= w_dec;
                        r_miss <= w_miss_inc;
                    end
                end
            endcase
        end
    end

    assign data   = r_data;
    assign ctrl   = r_ctrl;
    assign de     = r_de;
    assign locked = (r_state == ST_LOCKED);
    assign offset = r_offset;

endmodule
